// File: rtl/lfsr_period_monitor.sv
// Measures the repeat period of an LFSR sample stream: captures the first
// nonzero sample as seed and counts accepted samples until it recurs.
module lfsr_period_monitor #(
  parameter int W  = 9,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] period,
  output logic          lockup,
  output logic          max_len,
  output logic          timeout,
  output logic [1:0]    state_dbg
);

  // Handshake: a sample is consumed on every rising edge where in_valid is
  // high; there is no backpressure, so busy is status only, not a ready.

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_COUNT   = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [CW-1:0] LIM        = {CW{1'b1}};
  localparam logic [CW-1:0] MAX_PERIOD = CW'((2 ** W) - 1);

  logic [1:0]    state;
  logic [W-1:0]  seed;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // cnt stays below LIM in COUNT, so this sum never wraps.
  assign cnt_next  = cnt + 1'b1;
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= S_IDLE;
      seed    <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      period  <= '0;
      lockup  <= 1'b0;
      max_len <= 1'b0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_CAPTURE;
            busy  <= 1'b1;
          end
        end

        S_CAPTURE: begin
          if (in_valid) begin
            if (in_data != '0) begin
              seed  <= in_data;
              cnt   <= '0;
              state <= S_COUNT;
            end else begin
              lockup <= 1'b1;
              period <= '0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end
          end
        end

        S_COUNT: begin
          if (in_valid) begin
            // Seed match outranks lockup, which outranks timeout.
            if (in_data == seed) begin
              period  <= cnt_next;
              max_len <= (cnt_next == MAX_PERIOD);
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= S_DONE;
            end else if (in_data == '0) begin
              lockup <= 1'b1;
              period <= '0;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end else if (cnt_next == LIM) begin
              timeout <= 1'b1;
              period  <= '0;
              done    <= 1'b1;
              busy    <= 1'b0;
              state   <= S_DONE;
            end else begin
              cnt <= cnt_next;
            end
          end
        end

        S_DONE: begin
          if (start) begin
            period  <= '0;
            lockup  <= 1'b0;
            max_len <= 1'b0;
            timeout <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            state   <= S_CAPTURE;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed bench for lfsr_period_monitor: a vector table plus hand-written
// sequences for the long-period, timeout and asynchronous-reset cases.
module tb_lfsr_period_monitor;

  logic       clk;
  logic       rst_b;
  logic       start;
  logic       in_valid;
  logic [8:0] in_data;
  logic       busy;
  logic       done;
  logic [9:0] period;
  logic       lockup;
  logic       max_len;
  logic       timeout;
  logic [1:0] state_dbg;

  int n_vec;
  int n_err;

  typedef struct {
    logic       s;
    logic       iv;
    logic [8:0] d;
    logic       eb;
    logic       ed;
    logic [9:0] ep;
    logic       el;
    logic       em;
    logic       et;
  } vec_t;

  vec_t vq[$];

  lfsr_period_monitor #(.W(9), .CW(10)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .busy     (busy),
    .done     (done),
    .period   (period),
    .lockup   (lockup),
    .max_len  (max_len),
    .timeout  (timeout),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic add_vec(input logic s, input logic iv, input logic [8:0] d,
                         input logic eb, input logic ed, input logic [9:0] ep,
                         input logic el, input logic em, input logic et);
    vec_t v;
    v.s = s; v.iv = iv; v.d = d;
    v.eb = eb; v.ed = ed; v.ep = ep; v.el = el; v.em = em; v.et = et;
    vq.push_back(v);
  endtask

  task automatic step(input logic s, input logic iv, input logic [8:0] d);
    @(negedge clk);
    start    = s;
    in_valid = iv;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic eb, input logic ed,
                       input logic [9:0] ep, input logic el, input logic em,
                       input logic et);
    n_vec++;
    if ({busy, done, period, lockup, max_len, timeout} !== {eb, ed, ep, el, em, et}) begin
      n_err++;
      $display("FAIL %s: got busy=%b done=%b period=%0d lockup=%b max_len=%b timeout=%b, expected busy=%b done=%b period=%0d lockup=%b max_len=%b timeout=%b",
               name, busy, done, period, lockup, max_len, timeout, eb, ed, ep, el, em, et);
    end
  endtask

  function automatic logic [8:0] lfsr_next(input logic [8:0] s);
    return {s[7:0], s[8] ^ s[4]};
  endfunction

  initial begin
    logic [8:0] s;
    n_vec    = 0;
    n_err    = 0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rst_b    = 1'b0;

    //      s  iv data     busy done period lock max  tmo
    add_vec(0, 1, 9'h0A5,  0,   0,   0,     0,   0,   0); // IDLE ignores samples
    add_vec(1, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h0A5,  1,   0,   0,     0,   0,   0); // seed
    add_vec(0, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h13C,  1,   0,   0,     0,   0,   0);
    add_vec(0, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(1, 0, 9'h000,  1,   0,   0,     0,   0,   0); // start while busy
    add_vec(0, 1, 9'h007,  1,   0,   0,     0,   0,   0);
    add_vec(0, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h0A5,  0,   1,   3,     0,   0,   0); // repeat -> period 3
    add_vec(0, 0, 9'h000,  0,   1,   3,     0,   0,   0);
    add_vec(0, 1, 9'h0A5,  0,   1,   3,     0,   0,   0); // DONE holds
    add_vec(1, 0, 9'h000,  1,   0,   0,     0,   0,   0); // restart clears
    add_vec(0, 1, 9'h000,  0,   1,   0,     1,   0,   0); // zero first sample
    add_vec(0, 0, 9'h000,  0,   1,   0,     1,   0,   0);
    add_vec(1, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h055,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h055,  0,   1,   1,     0,   0,   0); // immediate repeat
    add_vec(1, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h033,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h044,  1,   0,   0,     0,   0,   0);
    add_vec(0, 1, 9'h000,  0,   1,   0,     1,   0,   0); // lockup mid-count
    add_vec(1, 0, 9'h000,  1,   0,   0,     0,   0,   0);
    add_vec(1, 1, 9'h011,  1,   0,   0,     0,   0,   0);
    add_vec(1, 1, 9'h011,  0,   1,   1,     0,   0,   0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_b = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].s, vq[i].iv, vq[i].d);
      check($sformatf("vec%0d", i), vq[i].eb, vq[i].ed, vq[i].ep,
            vq[i].el, vq[i].em, vq[i].et);
    end

    // Maximal-length LFSR seeded 9'h001
    step(1, 0, 9'h000);
    step(0, 1, 9'h001);
    check("lfsr_seed", 1, 0, 0, 0, 0, 0);
    s = 9'h001;
    for (int k = 1; k <= 511; k++) begin
      s = lfsr_next(s);
      step(0, 1, s);
      if (k == 510) check("lfsr_before_repeat", 1, 0, 0, 0, 0, 0);
    end
    check("lfsr_period", 0, 1, 10'd511, 0, 1, 0);

    // Never-repeating stream: timeout on the 1023rd post-seed sample
    step(1, 0, 9'h000);
    step(0, 1, 9'h001);
    for (int k = 0; k < 1023; k++) begin
      step(0, 1, 9'(2 + (k % 510)));
      if (k == 1021) check("timeout_before", 1, 0, 0, 0, 0, 0);
    end
    check("timeout", 0, 1, 0, 0, 0, 1);

    // Seed match on the 1023rd sample outranks timeout
    step(1, 0, 9'h000);
    step(0, 1, 9'h001);
    for (int k = 0; k < 1022; k++) step(0, 1, 9'(2 + (k % 510)));
    check("match_at_limit_before", 1, 0, 0, 0, 0, 0);
    step(0, 1, 9'h001);
    check("match_at_limit", 0, 1, 10'd1023, 0, 0, 0);

    // Asynchronous reset in the middle of a measurement
    step(1, 0, 9'h000);
    step(0, 1, 9'h0A5);
    step(0, 1, 9'h100);
    step(0, 1, 9'h002);
    check("pre_reset_busy", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_b = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_b = 1'b1;
    step(0, 1, 9'h0A5);
    step(0, 1, 9'h0A5);
    check("idle_after_reset", 0, 0, 0, 0, 0, 0);
    step(1, 0, 9'h000);
    step(0, 1, 9'h0A5);
    step(0, 1, 9'h0A5);
    check("remeasure_after_reset", 0, 1, 1, 0, 0, 0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
LFSR_PERIOD_MONITOR -- requirements
Module: lfsr_period_monitor

Interface
REQ-001 SHALL have parameter W, default 9, width of the monitored sample.
REQ-002 SHALL have parameter CW, default 10, width of the period counter; limit LIM = 2^CW - 1 = 1023.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a measurement.
REQ-006 SHALL have port in_valid  input  1  in_data is a new LFSR sample this cycle.
REQ-007 SHALL have port in_data  input  W  LFSR state word from the upstream generator.
REQ-008 SHALL have port busy  output  1  high in CAPTURE and COUNT.
REQ-009 SHALL have port done  output  1  high while in DONE; results valid.
REQ-010 SHALL have port period  output  CW  measured sequence period; 0 if none found.
REQ-011 SHALL have port lockup  output  1  an all-zero sample was seen.
REQ-012 SHALL have port max_len  output  1  period == 2^W - 1 (511).
REQ-013 SHALL have port timeout  output  1  no repeat within LIM samples.

Function
REQ-014 SHALL implement FSM states IDLE, CAPTURE, COUNT, DONE; all outputs registered.
REQ-015 IDLE: start=1 -> CAPTURE; other inputs ignored.
REQ-016 CAPTURE: on in_valid, in_data != 0 -> store seed=in_data, cnt=0, go COUNT; in_data == 0 -> lockup=1, period=0, go DONE.
REQ-017 COUNT: each in_valid sample SHALL increment cnt by 1; cycles with in_valid=0 SHALL hold all state.
REQ-018 COUNT, sample == seed -> period = cnt+1 (samples after seed up to and including the repeat), go DONE.
REQ-019 COUNT, sample == 0 (and != seed) -> lockup=1, period=0, go DONE.
REQ-020 COUNT, sample accepted with cnt+1 == LIM and no match -> timeout=1, period=0, go DONE.
REQ-021 Priority on the same sample: seed match > lockup > timeout.
REQ-022 done SHALL rise the clock edge after the terminating sample is accepted (latency 1 cycle).
REQ-023 max_len SHALL be set together with done when period == 511, else 0.
REQ-024 DONE: outputs held until start=1, which clears period, lockup, max_len, timeout, done and goes CAPTURE.
REQ-025 start while busy SHALL be ignored (no restart, no counter clear).
REQ-026 Counter SHALL never wrap; cnt saturates path is replaced by timeout per REQ-020.
REQ-027 Only one of lockup, timeout, or nonzero period SHALL be asserted in DONE.

Reset
REQ-028 rst_b=0 SHALL immediately force IDLE, cnt=0, seed=0, and busy, done, period, lockup, max_len, timeout all 0, regardless of state.
REQ-029 rst_b deassertion SHALL leave the block in IDLE awaiting start; an in-flight measurement is discarded.

Verification
REQ-030 start, then continuous valid samples of maximal 9-bit LFSR (x^9+x^5+1) seeded 9'h001 -> done after 511 samples past seed, period=511, max_len=1, lockup=0, timeout=0.
REQ-031 start, first sample 9'h000 (reset-state LFSR with XOR feedback) -> done next cycle, lockup=1, period=0, busy=0.
REQ-032 start, samples 9'h0A5, 9'h13C, 9'h007, 9'h0A5 with in_valid gaps of 0-3 cycles -> period=3, max_len=0; gaps do not change result.
REQ-033 start, incrementing samples 1,2,3,... never repeating seed -> timeout=1 exactly on the 1023rd post-seed sample, period=0.
REQ-034 start pulsed again mid-COUNT -> ignored, final period unchanged; second start in DONE clears flags and re-measures.
REQ-035 rst_b pulsed low mid-COUNT -> all outputs 0 asynchronously, IDLE after release, no done until a new start.
